// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: register index, writeback
// source select, controller state and the bundled per-stage control word.
package hazard_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        from_ALU     = 2'd0,
        from_DataMem = 2'd1,
        from_PC4     = 2'd2,
        from_Imm     = 2'd3
    } MReg_sel_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Per-stage enable/flush generation from dmem wait, taken branch and load-use,
// with a dmem timeout watchdog and stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_regwrite,
    input  logic [1:0]       id_ex_MReg,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    hz_state_e         state_q;
    logic [WAIT_W-1:0] wait_q;
    pipe_ctrl_t        ctrl;
    logic              running;
    logic              mem_stall;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    assign running   = (state_q == RUN) || (state_q == MEM_WAIT);
    assign mem_stall = dmem_req && !dmem_ready;
    assign load_use  = id_ex_regwrite
                    && (MReg_sel_e'(id_ex_MReg) == from_DataMem)
                    && (id_ex_rd != 5'd0)
                    && ((id_uses_rs1 && (id_rs1 == id_ex_rd))
                     || (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // Priority: a dmem freeze holds any pending branch so it re-resolves later.
    always_comb begin
        ctrl = '0;
        if (running) begin
            if (mem_stall) begin
                ctrl.mem_wb_en    = 1'b1;
                ctrl.mem_wb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                ctrl             = '1;
                ctrl.mem_wb_flush = 1'b0;
            end else if (load_use) begin
                ctrl.id_ex_en    = 1'b1;
                ctrl.ex_mem_en   = 1'b1;
                ctrl.mem_wb_en   = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else begin
                ctrl.pc_en     = 1'b1;
                ctrl.if_id_en  = 1'b1;
                ctrl.id_ex_en  = 1'b1;
                ctrl.ex_mem_en = 1'b1;
                ctrl.mem_wb_en = 1'b1;
            end
        end
    end

    assign stall_inc = running && (mem_stall || load_use);
    assign flush_inc = running && !mem_stall && ex_branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (mem_stall) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state_q <= RUN;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                        // This cycle is the TIMEOUT-th consecutive stall spent waiting.
                        if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                            state_q <= HALT;
                        end
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign halted       = (state_q == HALT);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs1, id_rs2, id_ex_rd;
    logic             id_uses_rs1, id_uses_rs2, id_ex_regwrite;
    logic [1:0]       id_ex_MReg;
    logic             ex_branch_taken, dmem_req, dmem_ready;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       dbg_state;
    logic [7:0]       ctrl_v;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = first cycle after reset, 1 = running, 2 = halted.
    int m_phase;
    int m_consec;
    int m_stall;
    int m_flush;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_MReg      (id_ex_MReg),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .dbg_state_o     (dbg_state)
    );

    assign ctrl_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, mem_wb_flush};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic neutral_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_rd = 5'd0; id_ex_regwrite = 1'b0; id_ex_MReg = from_ALU;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    function automatic logic model_load_use();
        return id_ex_regwrite && (id_ex_MReg == from_DataMem) && (id_ex_rd != 5'd0)
            && ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
    endfunction

    // One clock: check combinational controls, advance model at the edge, check registered outputs.
    task automatic step(string tag);
        logic [7:0] exp_ctrl;
        logic       stall, lu;
        @(negedge clk);
        stall = dmem_req && !dmem_ready;
        lu    = model_load_use();
        exp_ctrl = 8'b00000_000;
        if (m_phase == 1) begin
            if (stall)                exp_ctrl = 8'b00001_001;
            else if (ex_branch_taken) exp_ctrl = 8'b11111_110;
            else if (lu)              exp_ctrl = 8'b00111_010;
            else                      exp_ctrl = 8'b11111_000;
        end
        check({tag, ".ctrl"}, 32'(ctrl_v), 32'(exp_ctrl));
        @(posedge clk);
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (stall || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (!stall && ex_branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            m_consec = stall ? m_consec + 1 : 0;
            if (m_consec == TIMEOUT + 1) m_phase = 2;
        end
        #1;
        check({tag, ".halted"}, 32'(halted), 32'(m_phase == 2));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    endtask

    // Hold reset 3 edges, release just after an edge.
    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ctrl", 32'(ctrl_v), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.counts", {stall_cnt, flush_cnt}, 32'd0);
        rst = 1'b0;
        m_phase = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    endtask

    initial begin
        neutral_inputs();
        reset_dut();
        // Release: one IDLE cycle with everything off, then fetch enabled.
        step("idle");
        step("first_run");
        check("first_run.pc_en_was", 32'(m_phase), 32'd1);

        // Load-use on rs1 = x5: one bubble.
        id_ex_regwrite = 1'b1; id_ex_MReg = from_DataMem; id_ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        step("lu");
        neutral_inputs();
        step("lu_after");
        check("lu.stall_cnt", 32'(stall_cnt), 32'd1);

        // Load-use false cases.
        id_ex_regwrite = 1'b1; id_ex_MReg = from_DataMem; id_ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        step("lu_x0");
        neutral_inputs();
        id_ex_regwrite = 1'b1; id_ex_MReg = from_DataMem; id_ex_rd = 5'd7;
        id_rs2 = 5'd7; id_uses_rs2 = 1'b0; id_uses_rs1 = 1'b1; id_rs1 = 5'd3;
        step("lu_rs2_unused");
        neutral_inputs();
        id_ex_regwrite = 1'b1; id_ex_MReg = from_ALU; id_ex_rd = 5'd9;
        id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        step("lu_not_load");
        neutral_inputs();
        check("lu_false.stall_cnt", 32'(stall_cnt), 32'd1);

        // Taken branch.
        ex_branch_taken = 1'b1;
        step("br");
        ex_branch_taken = 1'b0;
        step("br_after");
        check("br.flush_cnt", 32'(flush_cnt), 32'd1);

        // Mem wait with a branch held in EX throughout.
        reset_dut();
        step("mw_idle");
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) step("mw_frozen");
        dmem_ready = 1'b1;
        step("mw_ready");
        neutral_inputs();
        check("mw.stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw.flush_cnt", 32'(flush_cnt), 32'd1);

        // Watchdog: halted after TIMEOUT+1 consecutive stall cycles.
        reset_dut();
        step("to_idle");
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT + 1; i++) step("to_wait");
        check("to.halted", 32'(halted), 32'd1);
        check("to.stall_cnt", 32'(stall_cnt), 32'(TIMEOUT + 1));
        dmem_ready = 1'b1;
        step("to_halt_hold");
        #2 rst = 1'b1;
        #1;
        check("to.async_rst_halted", 32'(halted), 32'd0);
        check("to.async_rst_state", 32'(dbg_state), 32'd0);
        neutral_inputs();
        reset_dut();

        // Randomized traffic, resetting whenever the model halts.
        for (int n = 0; n < 1500; n++) begin
            if (m_phase == 2) begin
                neutral_inputs();
                reset_dut();
            end
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_ex_rd        = 5'($urandom_range(0, 3));
            id_ex_regwrite  = ($urandom_range(0, 3) != 0);
            id_ex_MReg      = 2'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            dmem_req        = ($urandom_range(0, 9) < 4);
            dmem_ready      = ($urandom_range(0, 9) < 5);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It generates the per-stage enable and flush signals for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three causes: data-memory wait, taken branch or jump, and load-use hazard. It includes a data-memory timeout watchdog and stall/flush performance counters. It sits in Top beside the forwarding unit: the forwarding unit resolves ALU-result hazards, and this block resolves the cases forwarding cannot cover.

## Interface
Parameters:
- TIMEOUT, 64: maximum consecutive dmem wait cycles before the block halts.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous and active-high
- id_rs1, id_rs2  in  reg_idx_t  source registers of the instruction in IF_ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads that source
- id_ex_rd  in  reg_idx_t  destination register in ID_EX
- id_ex_regwrite  in  1  ID_EX instruction writes a register
- id_ex_MReg  in  MReg_sel_e  ID_EX writeback source; from_DataMem means a load
- ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle
- dmem_req  in  1  EX_MEM holds a load or store accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  synchronous bubble insert; takes priority over the enable in the pipeline register
- halted  out  1  sticky: dmem timeout occurred
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
State machine (hz_state_e): IDLE, RUN, MEM_WAIT, HALT.
- rst asserted: state goes to IDLE and both counters and the wait counter clear.
- IDLE:
  - All enables are 0 and all flushes are 0.
  - Moves to RUN unconditionally at the next clk edge.
- RUN and MEM_WAIT share the same output equations. Evaluate in priority order:
  1. mem_stall = dmem_req & ~dmem_ready:
     - All enables 0 except mem_wb_en.
     - mem_wb_flush = 1.
     - No other flush is asserted. A branch present in EX is held and re-resolved on a later cycle.
  2. ex_branch_taken:
     - All enables 1.
     - if_id_flush = 1 and id_ex_flush = 1.
     - PC loads the target.
  3. load_use = id_ex_regwrite & (id_ex_MReg == from_DataMem) & (id_ex_rd != 0) & ((id_uses_rs1 & id_rs1 == id_ex_rd) | (id_uses_rs2 & id_rs2 == id_ex_rd)):
     - pc_en = 0 and if_id_en = 0.
     - id_ex_flush = 1.
     - ex_mem_en and mem_wb_en are 1.
  4. Otherwise: all enables 1 and all flushes 0.
- State transitions:
  - RUN goes to MEM_WAIT when mem_stall is true.
  - MEM_WAIT goes to RUN on the first cycle with dmem_ready = 1; that cycle the pipeline advances.
  - dmem_req dropping in MEM_WAIT also returns to RUN.
- Wait counter:
  - Clears on entry to MEM_WAIT, then increments each MEM_WAIT cycle with mem_stall true.
  - When it reaches TIMEOUT with mem_stall still true, the state goes to HALT.
- HALT:
  - All enables 0, flushes 0, halted = 1.
  - Exits only on rst.
- stall_cnt: +1 on each RUN or MEM_WAIT cycle where mem_stall or load_use is true. Saturates at all-ones.
- flush_cnt: +1 on each cycle where case 2 is selected. Saturates at all-ones.

## Timing
- Enable and flush outputs are combinational from the inputs and the current state, so they take effect at the same clk edge as the hazard.
- Counters and halted are registered and update at the edge that ends the event cycle.
- Reset values: state IDLE, all enables 0, all flushes 0, halted 0, stall_cnt 0, flush_cnt 0.
- Load-use costs exactly 1 bubble. Each mem wait cycle costs 1 cycle. A taken branch costs 2 squashed instructions.
- The first instruction fetch is enabled 1 cycle after rst deasserts, the IDLE cycle.
- rst asserted mid-MEM_WAIT goes to IDLE immediately. Partial wait counts are discarded.
- Halt timing: TIMEOUT = N means halted rises at the edge after the N-th consecutive MEM_WAIT stall cycle. That is N+1 stall cycles in total, including the RUN cycle that entered MEM_WAIT.

## Structure
- Add to riscv_pkg: hz_state_e (2-bit enum IDLE/RUN/MEM_WAIT/HALT), plus a pipe_ctrl_t struct bundling the 5 enables and 3 flushes for Top wiring. MReg_sel_e and reg_idx_t are already in the package.
- One sub-module is natural: sat_counter #(W), an enable-driven saturating counter, instantiated for stall_cnt and flush_cnt.
- The watchdog counter stays inline.

## Test plan
- Reset release: rst held 3 cycles, then released → 1 cycle with all enables 0, then pc_en = 1. stall_cnt = flush_cnt = 0.
- Load-use: ID_EX is a load with rd = x5, and IF_ID reads rs1 = x5 → exactly 1 cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1. stall_cnt = 1.
- Load-use false cases, each → no stall:
  - rd = x0;
  - id_uses_rs2 = 0 with rs2 = rd;
  - ID_EX MReg not from_DataMem.
- Branch: ex_branch_taken = 1 → if_id_flush = id_ex_flush = 1 for 1 cycle, and flush_cnt increments by 1.
- Mem wait plus simultaneous branch: dmem_req = 1, dmem_ready low for 3 cycles, ex_branch_taken = 1 throughout →
  - 3 frozen cycles with mem_wb_flush = 1 and no IF/ID flush;
  - on the ready cycle the branch flush fires;
  - stall_cnt = 3, flush_cnt = 1.
- Timeout: TIMEOUT = 4 and dmem_ready stuck at 0 →
  - halted = 1 after 5 stall cycles and all enables stay 0;
  - asserting rst mid-halt clears halted asynchronously.
